// File: rtl/ansi_vram_decoder.sv
// ansi_vram_decoder: parses the ANSI/VT100 subset emitted by the GPU serial renderer
// (CUP, SGR, ED, private modes) and writes 16-bit cells into VRAM.
// Ports: CLK/RESET (async, active high); RX_DATA/RX_VALID byte strobe in;
//   VRAM_LOCK in (GPU owns VRAM); VRAM_ENABLE/VRAM_WRITE/VRAM_ADDR/VRAM_DATA_W write port out;
//   BUSY (write pending or clear running); OVERRUN (sticky, byte dropped).
module ansi_vram_decoder #(
  parameter int OFFSET_Y = 5,
  parameter int OFFSET_X = 9
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        VRAM_LOCK,
  output logic        VRAM_ENABLE,
  output logic        VRAM_WRITE,
  output logic [9:0]  VRAM_ADDR,
  output logic [15:0] VRAM_DATA_W,
  output logic        BUSY,
  output logic        OVERRUN
);

  typedef enum logic [1:0] {GROUND, ESCAPE, CSI} state_t;

  // Attribute byte layout: {bold, underline, fg[2:0], bg[2:0]}
  localparam logic [7:0] ATTR_DEF = 8'h38;
  localparam logic [7:0] WIN_Y0 = 8'(OFFSET_Y);
  localparam logic [7:0] WIN_Y1 = 8'(OFFSET_Y + 16);
  localparam logic [7:0] WIN_X0 = 8'(OFFSET_X);
  localparam logic [7:0] WIN_X1 = 8'(OFFSET_X + 64);

  state_t      state_q, state_d;
  logic [6:0]  ty_q, ty_d, tx_q, tx_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  sgr_q, sgr_d;      // shadow attrs, committed only on a non-private 'm'
  logic        priv_q, priv_d;
  logic        first_q, first_d;
  logic [6:0]  acc_q, acc_d;
  logic [6:0]  p0_q, p0_d, p1_q, p1_d;
  logic [1:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [9:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_dat_q, pend_dat_d;
  logic        clr_q, clr_d;
  logic [9:0]  clr_addr_q, clr_addr_d;
  logic        en_q, en_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] dat_q, dat_d;
  logic        ovr_q, ovr_d;

  logic [6:0] fp0, fp1;
  logic [9:0] mul;
  logic       clr_last, blocked, accept, printable, in_win;
  logic [9:0] wr_addr;

  function automatic logic [7:0] sgr_apply(input logic [7:0] a, input logic [6:0] p);
    logic [7:0] r;
    r = a;
    if (p == 7'd0)                      r = ATTR_DEF;
    else if (p == 7'd1)                 r[7] = 1'b1;
    else if (p == 7'd4)                 r[6] = 1'b1;
    else if (p >= 7'd30 && p <= 7'd37)  r[5:3] = 3'(p - 7'd30);
    else if (p >= 7'd40 && p <= 7'd47)  r[2:0] = 3'(p - 7'd40);
    return r;
  endfunction

  // Parameter values as seen by a final byte: the running accumulator closes the current slot.
  assign fp0 = (idx_q == 2'd0) ? acc_q : p0_q;
  assign fp1 = (idx_q == 2'd0) ? 7'd0 : ((idx_q == 2'd1) ? acc_q : p1_q);
  assign mul = 10'(acc_q) * 10'd10 + 10'(RX_DATA[3:0]);

  // A write leaving this cycle frees the slot, so a byte arriving now is not an overrun.
  assign clr_last  = clr_q & ~VRAM_LOCK & (clr_addr_q == 10'h3FF);
  assign blocked   = (pend_q & VRAM_LOCK) | (clr_q & ~clr_last);
  assign accept    = RX_VALID & ~blocked;
  assign printable = (RX_DATA >= 8'h20) && (RX_DATA <= 8'h7E);
  assign in_win    = ({1'b0, ty_q} >= WIN_Y0) && ({1'b0, ty_q} < WIN_Y1) &&
                     ({1'b0, tx_q} >= WIN_X0) && ({1'b0, tx_q} < WIN_X1);
  assign wr_addr   = {4'(ty_q - 7'(OFFSET_Y)), 6'(tx_q - 7'(OFFSET_X))};

  always_comb begin
    state_d     = state_q;
    ty_d        = ty_q;
    tx_d        = tx_q;
    attr_d      = attr_q;
    sgr_d       = sgr_q;
    priv_d      = priv_q;
    first_d     = first_q;
    acc_d       = acc_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    clr_d       = clr_q;
    clr_addr_d  = clr_addr_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    dat_d       = dat_q;
    ovr_d       = ovr_q | (RX_VALID & blocked);

    // Write port: clear and pending write are never active together.
    if (clr_q && !VRAM_LOCK) begin
      en_d       = 1'b1;
      addr_d     = clr_addr_q;
      dat_d      = 16'h0000;
      clr_addr_d = clr_addr_q + 10'd1;
      if (clr_last) clr_d = 1'b0;
    end else if (pend_q && !VRAM_LOCK) begin
      en_d   = 1'b1;
      addr_d = pend_addr_q;
      dat_d  = pend_dat_q;
      pend_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        GROUND: begin
          if (RX_DATA == 8'h1B) begin
            state_d = ESCAPE;
          end else if (RX_DATA == 8'h0D) begin
            tx_d = 7'd1;
          end else if (RX_DATA == 8'h0A) begin
            ty_d = (ty_q == 7'd127) ? ty_q : ty_q + 7'd1;
          end else if (printable) begin
            tx_d = (tx_q == 7'd127) ? tx_q : tx_q + 7'd1;
            if (in_win) begin
              // Direct issue only when the port is idle; otherwise park it in the pending slot.
              if (!VRAM_LOCK && !pend_q && !clr_q) begin
                en_d   = 1'b1;
                addr_d = wr_addr;
                dat_d  = {attr_q, RX_DATA};
              end else begin
                pend_d      = 1'b1;
                pend_addr_d = wr_addr;
                pend_dat_d  = {attr_q, RX_DATA};
              end
            end
          end
        end
        ESCAPE: begin
          if (RX_DATA == 8'h5B) begin
            state_d = CSI;
            priv_d  = 1'b0;
            first_d = 1'b1;
            acc_d   = 7'd0;
            p0_d    = 7'd0;
            p1_d    = 7'd0;
            idx_d   = 2'd0;
            sgr_d   = attr_q;
          end else begin
            state_d = GROUND;
          end
        end
        CSI: begin
          first_d = 1'b0;
          if (RX_DATA >= 8'h30 && RX_DATA <= 8'h39) begin
            acc_d = (mul > 10'd99) ? 7'd99 : mul[6:0];
          end else if (RX_DATA == 8'h3B) begin
            if (idx_q == 2'd0) p0_d = acc_q;
            if (idx_q == 2'd1) p1_d = acc_q;
            if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
            sgr_d = sgr_apply(sgr_q, acc_q);
            acc_d = 7'd0;
          end else if (RX_DATA == 8'h3F && first_q) begin
            priv_d = 1'b1;
          end else if (RX_DATA >= 8'h40 && RX_DATA <= 8'h7E) begin
            state_d = GROUND;
            if (!priv_q) begin
              if (RX_DATA == 8'h48) begin
                ty_d = (fp0 == 7'd0) ? 7'd1 : fp0;
                tx_d = (fp1 == 7'd0) ? 7'd1 : fp1;
              end else if (RX_DATA == 8'h6D) begin
                attr_d = sgr_apply(sgr_q, acc_q);
              end else if (RX_DATA == 8'h4A && fp0 == 7'd2) begin
                clr_d      = 1'b1;
                clr_addr_d = 10'd0;
              end
            end
          end else begin
            state_d = GROUND;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= GROUND;
      ty_q        <= 7'd1;
      tx_q        <= 7'd1;
      attr_q      <= ATTR_DEF;
      sgr_q       <= ATTR_DEF;
      priv_q      <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= 7'd0;
      p0_q        <= 7'd0;
      p1_q        <= 7'd0;
      idx_q       <= 2'd0;
      pend_q      <= 1'b0;
      pend_addr_q <= 10'd0;
      pend_dat_q  <= 16'd0;
      clr_q       <= 1'b0;
      clr_addr_q  <= 10'd0;
      en_q        <= 1'b0;
      addr_q      <= 10'd0;
      dat_q       <= 16'd0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ty_q        <= ty_d;
      tx_q        <= tx_d;
      attr_q      <= attr_d;
      sgr_q       <= sgr_d;
      priv_q      <= priv_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      clr_q       <= clr_d;
      clr_addr_q  <= clr_addr_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      ovr_q       <= ovr_d;
    end
  end

  assign VRAM_ENABLE = en_q;
  assign VRAM_WRITE  = en_q;
  assign VRAM_ADDR   = addr_q;
  assign VRAM_DATA_W = dat_q;
  assign BUSY        = pend_q | clr_q;
  assign OVERRUN     = ovr_q;

endmodule
